// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receive deserializer: locks byte alignment on a run of COM
// symbols, then presents each completed symbol for eight bit-clock cycles.
`timescale 1ns/1ps

module serial_to_parallel_rx #(
  parameter logic [7:0]  COM_SYMBOL  = 8'hBC,
  parameter int unsigned ALIGN_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(ALIGN_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   sh;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    com_cnt;

  logic [BYTE_W-1:0]   nxt_c;
  logic                nxt_is_com_c;
  logic                byte_done_c;

  // Candidate symbol including the bit being sampled at this edge.
  assign nxt_c        = {sh[BYTE_W-2:0], data_in};
  assign nxt_is_com_c = (nxt_c == COM_SYMBOL);
  assign byte_done_c  = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= SEARCH;
      sh        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sh <= nxt_c;
      unique case (state)
        SEARCH: begin
          // Bit-by-bit hunt; the edge completing a COM becomes the byte boundary.
          if (nxt_is_com_c) begin
            bit_cnt <= '0;
            com_cnt <= CNT_W'(1);
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (byte_done_c) begin
            if (nxt_is_com_c && (com_cnt == LOCK_LAST)) begin
              com_cnt <= '0;
              state   <= ACTIVE;
              active  <= 1'b1;
            end else if (nxt_is_com_c) begin
              com_cnt <= com_cnt + CNT_W'(1);
            end else begin
              com_cnt <= '0;
              state   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Locked: only byte boundaries matter, mid-byte COM patterns are ignored.
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (byte_done_c) begin
            data_out  <= nxt_c;
            valid_out <= !nxt_is_com_c;
          end
        end
        default: begin
          state   <= SEARCH;
          bit_cnt <= '0;
          com_cnt <= '0;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule
